// File: rtl/wave_capture.sv
// Writer side of the double-buffered waveform RAM. It arms on a rising zero crossing and writes 256 offset-binary samples into the half the display is not reading.
// Optional forced trigger after TRIGGER_TIMEOUT armed strobes: define WAVE_CAPTURE_TIMEOUT_EN.
module wave_capture #(
  parameter int SAMPLE_WIDTH    = 16,
  parameter int DECIMATION      = 1,
  parameter int TRIGGER_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [8:0]              write_address,
  output logic                    write_enable,
  output logic [7:0]              write_sample,
  output logic                    read_index
);

  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  state_t     state, state_next;
  logic [7:0] index, index_next;
  logic [7:0] dec_count, dec_next;
  logic       prev_msb;
  logic [7:0] s8, converted, write_index;
  logic       rising, dec_wrap, trigger, write_now, toggle_read;

  assign s8        = new_sample_in[SAMPLE_WIDTH-1 -: 8];
  assign converted = {~s8[7], s8[6:0]};
  assign rising    = prev_msb & ~s8[7];
  assign dec_wrap  = (dec_count == 8'(DECIMATION - 1));

  // Only the top byte of each sample is displayed; the rest is deliberately dropped.
  if (SAMPLE_WIDTH > 8) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^new_sample_in[SAMPLE_WIDTH-9:0];
  end

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TRIGGER_TIMEOUT + 1);
  logic [TW-1:0] timeout_count;
  logic          timeout_hit;

  assign timeout_hit = (timeout_count == TW'(TRIGGER_TIMEOUT - 1));
  assign trigger     = rising | timeout_hit;

  // Counts strobes spent in ARMED; cleared whenever the block is elsewhere so each arming starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timeout_count <= '0;
    else if (state != ARMED)
      timeout_count <= '0;
    else if (new_sample_ready)
      timeout_count <= timeout_count + 1'b1;
  end
`else
  assign trigger = rising;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      index     <= '0;
      dec_count <= '0;
      prev_msb  <= 1'b0;
    end else begin
      state     <= state_next;
      index     <= index_next;
      dec_count <= dec_next;
      if (new_sample_ready)
        prev_msb <= s8[7];
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    dec_next   = dec_count;
    case (state)
      ARMED: begin
        if (new_sample_ready && trigger) begin
          state_next = ACTIVE;
          index_next = 8'd1;
          dec_next   = '0;
        end
      end
      ACTIVE: begin
        if (new_sample_ready) begin
          dec_next = dec_wrap ? 8'd0 : dec_count + 8'd1;
          if (dec_wrap) begin
            index_next = index + 8'd1;
            if (index == 8'd255)
              state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wave_display_idle)
          state_next = ARMED;
      end
      default: state_next = ARMED;
    endcase
  end

  always_comb begin
    write_now   = 1'b0;
    write_index = index;
    toggle_read = 1'b0;
    case (state)
      ARMED: begin
        if (new_sample_ready && trigger) begin
          write_now   = 1'b1;
          write_index = 8'd0;
        end
      end
      ACTIVE:  write_now   = new_sample_ready & dec_wrap;
      WAIT:    toggle_read = wave_display_idle;
      default: write_now   = 1'b0;
    endcase
  end

  // Writes always target the half opposite the display, so the displayed half stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
      read_index    <= 1'b0;
    end else begin
      write_enable <= write_now;
      if (write_now) begin
        write_address <= {~read_index, write_index};
        write_sample  <= converted;
      end
      if (toggle_read)
        read_index <= ~read_index;
    end
  end

endmodule
